// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and flag controller for an asynchronous FIFO.
// Exports the Gray read pointer and derives empty/occupancy from the synced write pointer.
module rptr_empty_ctrl #(
  parameter int width    = 4,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width:0]   wptr_sync,
  input  logic             r_en,
  output logic [width:0]   rptr,
  output logic [width-1:0] r_addr,
  output logic             empty,
  output logic             almost_empty,
  output logic [width:0]   rd_count,
  output logic             rd_valid,
  output logic             underflow
);

  logic [width:0] rbin_q, rbin_d;
  logic [width:0] rgray_q, rgray_d;
  logic [width:0] cnt_q, cnt_d;
  logic           empty_q, empty_d;
  logic           ae_q, ae_d;
  logic           valid_q, valid_d;
  logic           uf_q, uf_d;
  logic           rd_acc;
  logic [width:0] wbin;
  logic [width:0] occ;

  always_comb begin
    rd_acc  = r_en & ~empty_q;
    rbin_d  = rbin_q + (width+1)'(rd_acc);
    rgray_d = (rbin_d >> 1) ^ rbin_d;
    wbin    = '0;
    // Each binary bit is the XOR of its Gray bit and all bits above it
    for (int i = 0; i <= width; i++) begin
      wbin[i] = ^(wptr_sync >> i);
    end
    occ     = wbin - rbin_d;
    empty_d = (rgray_d == wptr_sync);
    cnt_d   = occ;
    ae_d    = (32'(occ) <= AE_LEVEL);
    valid_d = rd_acc;
    uf_d    = uf_q | (r_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      valid_q <= valid_d;
      uf_q    <= uf_d;
    end
  end

  assign rptr         = rgray_q;
  assign r_addr       = rbin_q[width-1:0];
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_count     = cnt_q;
  assign rd_valid     = valid_q;
  assign underflow    = uf_q;

endmodule

// File: doc/rptr_empty_ctrl.md
Name: rptr_empty_ctrl

Overview:
- Read-side pointer and flag controller for the asynchronous FIFO. It is the counterpart of the write-pointer/full logic.
- Lives entirely in the read clock domain. It holds the binary read address and the Gray read pointer; the Gray pointer is exported for synchronisation into the write domain.
- Consumes the write pointer already synchronised into the read domain. Produces empty, almost_empty, an occupancy count, a read-data-valid strobe and a sticky underflow flag.

Parameters:
- width, 4, address width; FIFO depth = 2^width; pointers are width+1 bits.
- AE_LEVEL, 2, almost_empty asserts when occupancy <= AE_LEVEL; legal range 0..2^width-1.

Ports:
- clk  input  1  read-domain clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- wptr_sync  input  width+1  Gray write pointer, already 2-FF synchronised into clk domain.
- r_en  input  1  read request from the consumer.
- rptr  output  width+1  registered Gray read pointer, to the write-domain synchroniser.
- r_addr  output  width  binary read address to the RAM; equals rbin[width-1:0].
- empty  output  1  registered; FIFO empty as seen from the read domain.
- almost_empty  output  1  registered; occupancy <= AE_LEVEL.
- rd_count  output  width+1  registered occupancy, 0..2^width.
- rd_valid  output  1  RAM read data valid; one cycle after an accepted read.
- underflow  output  1  sticky; set by a read attempted while empty.

Behaviour:
- Internal registers: rbin (width+1), rgray (width+1). rptr = rgray. r_addr = rbin[width-1:0].
- Accepted read: rd_acc = r_en && !empty. Use the registered empty, never the next-state value.
- rbin_next = rbin + rd_acc, modulo 2^(width+1).
- rgray_next = (rbin_next >> 1) ^ rbin_next.
- wbin_sync = Gray-to-binary of wptr_sync, combinational: MSB passes through; each lower bit is the XOR of all higher Gray bits and itself.
- occ_next = (wbin_sync - rbin_next), modulo 2^(width+1).
- Reset values (reset high at posedge):
  - rbin = 0, rgray = 0, rptr = 0, r_addr = 0.
  - empty = 1, almost_empty = 1, rd_count = 0, rd_valid = 0, underflow = 0.
- Reset has priority over all other inputs. Reset asserted mid-operation discards in-flight state; rd_valid is 0 in the cycle after reset.
- Normal cycle updates (all registered, one-cycle latency):
  - rbin <= rbin_next; rgray <= rgray_next.
  - empty <= (rgray_next == wptr_sync): full (width+1)-bit Gray compare, including the wrap bit.
  - rd_count <= occ_next.
  - almost_empty <= (occ_next <= AE_LEVEL).
  - rd_valid <= rd_acc. RAM read latency is 1; data at r_addr sampled at the accepting edge is valid while rd_valid = 1.
  - underflow <= underflow | (r_en && empty).
- Read while empty: pointers hold, rd_valid stays 0, underflow sets and stays set until reset.
- Empty deassertion: a new wptr_sync value is reflected in empty, rd_count and almost_empty exactly one clk later. This is the inherent pessimism of the synchronised pointer.
- Last entry: reading the last entry sets empty on the very next edge, so back-to-back r_en never underflows.
- Simultaneous read and wptr_sync advance: both are folded into the same cycle's occ_next and empty computation.
- Wrap-around:
  - rbin wraps from 2^(width+1)-1 to 0.
  - The Gray MSB toggles each time r_addr wraps.
  - Empty equality is valid across the wrap because the full pointers are compared.
- Pointer encoding: rptr changes by exactly one bit per accepted read; it never changes without an accepted read.
- rd_count when full: rd_count = 2^width is legal. Values above 2^width indicate an upstream error and are not clamped.

Test Plan:
- Reset: hold reset 2 cycles with r_en=1 and wptr_sync=5'b00011 -> after release rptr=0, r_addr=0, empty=1, almost_empty=1, rd_count=0, rd_valid=0, underflow=0.
- Single entry: wptr_sync 0 -> 5'b00001 -> next cycle empty=0, rd_count=1, almost_empty=1. Pulse r_en one cycle -> next edge rbin=1, rptr=5'b00001, empty=1, rd_valid=1 for exactly one cycle.
- Almost-empty threshold (AE_LEVEL=2): wptr_sync = Gray(5) = 5'b00111 -> rd_count=5, almost_empty=0. Three back-to-back reads -> rd_count 4,3,2 on successive cycles; almost_empty=1 when rd_count=2.
- Underflow: empty=1, r_en=1 for one cycle -> rptr unchanged, rd_valid=0, underflow=1 and still 1 after 10 idle cycles; reset clears it to 0.
- Wrap: write side advances to Gray(16) = 5'b11000; read 16 times -> r_addr returns to 0, rptr=5'b11000, empty=1. Repeat 16 more with wptr_sync reaching Gray(32 mod 32) = 0 -> rptr=0, empty=1, underflow=0 throughout.
- Full occupancy: wptr_sync=5'b11000 with rptr=0 -> rd_count=16, empty=0. Continuous r_en for 16 cycles -> rd_valid high 16 consecutive cycles, empty=1 on the 16th edge, no underflow.
